// File: rtl/lsu_mem_initiator.sv
// rtl/lsu_mem_initiator.sv - byte-addressed load/store initiator for a word-addressed data memory
//
// Takes load/store requests from the execute stage and turns each one into a
// short sequence of full-word reads and writes. It handles:
// - sub-word stores as read-modify-write;
// - accesses that straddle two words, split into two word accesses;
// - sign and zero extension of load data;
// - rejection of illegal width codes and out-of-range addresses.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   req_valid/req_ready          request handshake
//   req_write, req_funct3        store flag and RV32I width code
//   req_addr, req_wdata, req_rd  byte address, store data, destination tag
//   resp_valid/resp_ready        response handshake
//   resp_rdata, resp_rd          extended load data, echoed tag
//   resp_err                     illegal funct3 or out-of-range access
//   mem_write, mem_funct3        word write strobe, fixed full-word width code
//   memory_address, write_data   word index and merged write word
//   read_data                    combinational read of memory_address

module lsu_mem_initiator #(
    parameter int DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic [4:0]  resp_rd,
    output logic        resp_err,
    output logic        mem_write,
    output logic [2:0]  mem_funct3,
    output logic [31:0] memory_address,
    output logic [31:0] write_data,
    input  logic [31:0] read_data
);

    typedef enum logic [2:0] {IDLE, RD0, WR0, RD1, WR1, RESP} state_t;

    localparam logic [30:0] DEPTH_W = 31'(DEPTH);

    function automatic logic [2:0] size_of(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] wdata_q, wdata_d;
    logic [4:0]  rd_q, rd_d;
    logic        write_q, write_d;
    logic        cross_q, cross_d;
    logic [31:0] word0_q, word0_d;
    logic [31:0] word1_q, word1_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;
    logic [31:0] mem_addr_q;

    // Decode of the incoming request, used only at the acceptance edge.
    // Word indices carry one extra bit so that w0+1 cannot wrap back into range.
    logic [2:0]  req_size;
    logic [3:0]  req_end;
    logic        req_cross;
    logic [30:0] req_w0, req_w1;
    logic        req_err;

    assign req_size  = size_of(req_funct3);
    assign req_end   = {2'b00, req_addr[1:0]} + {1'b0, req_size};
    assign req_cross = (req_end > 4'd4);
    assign req_w0    = {1'b0, req_addr[31:2]};
    assign req_w1    = req_w0 + 31'd1;

    always_comb begin
        req_err = 1'b0;
        if (req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11) req_err = 1'b1;
        if (req_write && req_funct3[2])                        req_err = 1'b1;
        if (req_w0 >= DEPTH_W)                                 req_err = 1'b1;
        if (req_cross && req_w1 >= DEPTH_W)                    req_err = 1'b1;
    end

    // Decode of the latched request.
    logic [1:0]  off;
    logic [31:0] w0, w1;
    logic [3:0]  size_mask;
    logic [7:0]  byte_mask;
    logic [63:0] bit_mask;
    logic [63:0] lane_data;
    logic [31:0] merge0, merge1;

    assign off = addr_q[1:0];
    assign w0  = {2'b00, addr_q[31:2]};
    assign w1  = w0 + 32'd1;

    // Store data and its byte mask are placed across an 8-byte window
    // {word1, word0}; the low half goes to WR0 and the high half to WR1.
    always_comb begin
        case (funct3_q[1:0])
            2'b00:   size_mask = 4'b0001;
            2'b01:   size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase
        byte_mask = {4'b0000, size_mask} << off;
        bit_mask  = '0;
        for (int i = 0; i < 8; i++) begin
            bit_mask[i*8 +: 8] = {8{byte_mask[i]}};
        end
        lane_data = {32'h0, wdata_q} << {off, 3'b000};
        merge0    = (word0_q & ~bit_mask[31:0])  | (lane_data[31:0]  & bit_mask[31:0]);
        merge1    = (word1_q & ~bit_mask[63:32]) | (lane_data[63:32] & bit_mask[63:32]);
    end

    // Load result: in RD1 the window is {word1 from memory, captured word0};
    // in RD0 (non-crossing) only the current word matters.
    logic [63:0] load_window;
    logic [31:0] load_win;
    logic [31:0] load_result;

    always_comb begin
        load_window = (state_q == RD1) ? {read_data, word0_q} : {32'h0, read_data};
        load_win    = 32'(load_window >> {off, 3'b000});
        case (funct3_q)
            3'b000:  load_result = {{24{load_win[7]}}, load_win[7:0]};
            3'b100:  load_result = {24'h0, load_win[7:0]};
            3'b001:  load_result = {{16{load_win[15]}}, load_win[15:0]};
            3'b101:  load_result = {16'h0, load_win[15:0]};
            default: load_result = load_win;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        funct3_d     = funct3_q;
        wdata_d      = wdata_q;
        rd_d         = rd_q;
        write_d      = write_q;
        cross_d      = cross_q;
        word0_d      = word0_q;
        word1_d      = word1_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d       = req_addr;
                    funct3_d     = req_funct3;
                    wdata_d      = req_wdata;
                    rd_d         = req_rd;
                    write_d      = req_write;
                    cross_d      = req_cross;
                    resp_rdata_d = 32'h0;
                    resp_err_d   = req_err;
                    state_d      = req_err ? RESP : RD0;
                end
            end
            RD0: begin
                word0_d = read_data;
                if (write_q) begin
                    state_d = WR0;
                end else if (cross_q) begin
                    state_d = RD1;
                end else begin
                    resp_rdata_d = load_result;
                    state_d      = RESP;
                end
            end
            WR0: begin
                state_d = cross_q ? RD1 : RESP;
            end
            RD1: begin
                word1_d = read_data;
                if (write_q) begin
                    state_d = WR1;
                end else begin
                    resp_rdata_d = load_result;
                    state_d      = RESP;
                end
            end
            WR1: begin
                state_d = RESP;
            end
            RESP: begin
                if (resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Memory-side outputs decode straight from state so that an asynchronous
    // reset removes the write strobe in the same cycle.
    always_comb begin
        mem_write      = 1'b0;
        write_data     = 32'h0;
        memory_address = mem_addr_q;
        case (state_q)
            RD0: memory_address = w0;
            WR0: begin
                memory_address = w0;
                mem_write      = 1'b1;
                write_data     = merge0;
            end
            RD1: memory_address = w1;
            WR1: begin
                memory_address = w1;
                mem_write      = 1'b1;
                write_data     = merge1;
            end
            default: ;
        endcase
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = resp_rdata_q;
    assign resp_rd    = rd_q;
    assign resp_err   = resp_err_q;
    assign mem_funct3 = 3'b010;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            addr_q       <= 32'h0;
            funct3_q     <= 3'b000;
            wdata_q      <= 32'h0;
            rd_q         <= 5'd0;
            write_q      <= 1'b0;
            cross_q      <= 1'b0;
            word0_q      <= 32'h0;
            word1_q      <= 32'h0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
            mem_addr_q   <= 32'h0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            funct3_q     <= funct3_d;
            wdata_q      <= wdata_d;
            rd_q         <= rd_d;
            write_q      <= write_d;
            cross_q      <= cross_d;
            word0_q      <= word0_d;
            word1_q      <= word1_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            mem_addr_q   <= memory_address;
        end
    end

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// tb/tb_lsu_mem_initiator.sv - directed bench for lsu_mem_initiator with a 16-word memory

module tb_lsu_mem_initiator;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic [4:0]  resp_rd;
    logic        resp_err;
    logic        mem_write;
    logic [2:0]  mem_funct3;
    logic [31:0] memory_address;
    logic [31:0] write_data;
    logic [31:0] read_data;

    lsu_mem_initiator #(.DEPTH(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_funct3     (req_funct3),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_rd         (req_rd),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_rdata     (resp_rdata),
        .resp_rd        (resp_rd),
        .resp_err       (resp_err),
        .mem_write      (mem_write),
        .mem_funct3     (mem_funct3),
        .memory_address (memory_address),
        .write_data     (write_data),
        .read_data      (read_data)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [16] = '{default: 32'h0};

    assign read_data = (memory_address < 32'd16) ? mem[memory_address[3:0]] : 32'h0;

    always @(posedge clk) begin
        if (mem_write && memory_address < 32'd16) mem[memory_address[3:0]] <= write_data;
    end

    typedef struct {
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_nwr;
        logic [31:0] exp_wa;
        logic [31:0] exp_wd;
    } vec_t;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [4:0] rd,
                                input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat,
                                input int exp_nwr, input logic [31:0] exp_wa, input logic [31:0] exp_wd);
        vec_t v;
        v.wr = wr; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rd = rd;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_lat = exp_lat;
        v.exp_nwr = exp_nwr; v.exp_wa = exp_wa; v.exp_wd = exp_wd;
        return v;
    endfunction

    // One full transaction with resp_ready held high. Latency N means
    // resp_valid is seen in the Nth cycle after the acceptance edge.
    task automatic do_req(input vec_t v, input string tag);
        int lat;
        int nwr;
        logic [31:0] wa, wd;
        lat = 0; nwr = 0; wa = 32'h0; wd = 32'h0;
        @(negedge clk);
        req_write  = v.wr;
        req_funct3 = v.f3;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        req_rd     = v.rd;
        req_valid  = 1'b1;
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (mem_write) begin
                if (nwr == 0) begin
                    wa = memory_address;
                    wd = write_data;
                end
                nwr++;
            end
            if (resp_valid) begin
                lat = c;
                break;
            end
        end
        chk({tag, "_latency"}, 32'(lat), 32'(v.exp_lat));
        chk({tag, "_rdata"}, resp_rdata, v.exp_rdata);
        chk({tag, "_err"}, 32'(resp_err), 32'(v.exp_err));
        chk({tag, "_rd"}, 32'(resp_rd), 32'(v.rd));
        chk({tag, "_nwrites"}, 32'(nwr), 32'(v.exp_nwr));
        if (v.exp_nwr != 0) begin
            chk({tag, "_wr_addr"}, wa, v.exp_wa);
            chk({tag, "_wr_data"}, wd, v.exp_wd);
        end
    endtask

    vec_t vecs [20];

    initial begin
        int  seen;
        // wr, f3, addr, wdata, rd, exp_rdata, exp_err, lat, nwr, first write addr, first write data
        vecs[0]  = mk(1, 3'b010, 32'h8,  32'hDEADBEEF, 5'd1,  32'h0,        0, 3, 1, 32'd2, 32'hDEADBEEF);
        vecs[1]  = mk(0, 3'b000, 32'hB,  32'h0,        5'd2,  32'hFFFFFFDE, 0, 2, 0, 32'd0, 32'h0);
        vecs[2]  = mk(0, 3'b100, 32'hB,  32'h0,        5'd3,  32'h000000DE, 0, 2, 0, 32'd0, 32'h0);
        vecs[3]  = mk(0, 3'b101, 32'hA,  32'h0,        5'd4,  32'h0000DEAD, 0, 2, 0, 32'd0, 32'h0);
        vecs[4]  = mk(1, 3'b001, 32'h7,  32'h1234AABB, 5'd5,  32'h0,        0, 5, 2, 32'd1, 32'hBB000000);
        vecs[5]  = mk(0, 3'b001, 32'h7,  32'h0,        5'd6,  32'hFFFFAABB, 0, 3, 0, 32'd0, 32'h0);
        vecs[6]  = mk(0, 3'b010, 32'h5,  32'h0,        5'd7,  32'hAABB0000, 0, 3, 0, 32'd0, 32'h0);
        vecs[7]  = mk(1, 3'b000, 32'h0,  32'hAAAAAA55, 5'd8,  32'h0,        0, 3, 1, 32'd0, 32'h00000055);
        vecs[8]  = mk(1, 3'b001, 32'h2,  32'h77778001, 5'd9,  32'h0,        0, 3, 1, 32'd0, 32'h80010055);
        vecs[9]  = mk(0, 3'b001, 32'h2,  32'h0,        5'd10, 32'hFFFF8001, 0, 2, 0, 32'd0, 32'h0);
        vecs[10] = mk(0, 3'b101, 32'h2,  32'h0,        5'd11, 32'h00008001, 0, 2, 0, 32'd0, 32'h0);
        vecs[11] = mk(0, 3'b010, 32'h0,  32'h0,        5'd12, 32'h80010055, 0, 2, 0, 32'd0, 32'h0);
        vecs[12] = mk(0, 3'b000, 32'h0,  32'h0,        5'd13, 32'h00000055, 0, 2, 0, 32'd0, 32'h0);
        vecs[13] = mk(0, 3'b010, 32'h3C, 32'h0,        5'd14, 32'h0,        0, 2, 0, 32'd0, 32'h0);
        vecs[14] = mk(0, 3'b010, 32'h40, 32'h0,        5'd15, 32'h0,        1, 1, 0, 32'd0, 32'h0);
        vecs[15] = mk(0, 3'b010, 32'h3E, 32'h0,        5'd16, 32'h0,        1, 1, 0, 32'd0, 32'h0);
        vecs[16] = mk(0, 3'b011, 32'h0,  32'h0,        5'd17, 32'h0,        1, 1, 0, 32'd0, 32'h0);
        vecs[17] = mk(1, 3'b100, 32'h0,  32'h000000FF, 5'd18, 32'h0,        1, 1, 0, 32'd0, 32'h0);
        vecs[18] = mk(1, 3'b111, 32'h4,  32'hFFFFFFFF, 5'd19, 32'h0,        1, 1, 0, 32'd0, 32'h0);
        vecs[19] = mk(0, 3'b000, 32'hFFFFFFFF, 32'h0,  5'd20, 32'h0,        1, 1, 0, 32'd0, 32'h0);

        rst        = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        req_rd     = 5'd0;
        resp_ready = 1'b1;

        #12;
        chk("reset_req_ready", 32'(req_ready), 32'd1);
        chk("reset_resp_valid", 32'(resp_valid), 32'd0);
        chk("reset_resp_err", 32'(resp_err), 32'd0);
        chk("reset_mem_write", 32'(mem_write), 32'd0);
        chk("reset_resp_rdata", resp_rdata, 32'h0);
        chk("reset_resp_rd", 32'(resp_rd), 32'd0);
        chk("reset_memory_address", memory_address, 32'h0);
        chk("reset_write_data", write_data, 32'h0);
        chk("mem_funct3", 32'(mem_funct3), 32'd2);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            do_req(vecs[i], $sformatf("v%0d", i));
        end

        chk("mem0_after_stores", mem[0], 32'h80010055);
        chk("mem1_after_stores", mem[1], 32'hBB000000);
        chk("mem2_after_stores", mem[2], 32'hDEADBEAA);

        // Backpressure: response must hold while a competing store is offered.
        @(negedge clk);
        resp_ready = 1'b0;
        req_write  = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h8;
        req_rd     = 5'd21;
        req_valid  = 1'b1;
        @(posedge clk);
        #1;
        req_write  = 1'b1;
        req_addr   = 32'hC;
        req_wdata  = 32'hCAFEF00D;
        req_rd     = 5'd22;
        seen = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (resp_valid) begin
                seen = c;
                break;
            end
        end
        chk("bp_latency", 32'(seen), 32'd2);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("bp_hold%0d_valid", k), 32'(resp_valid), 32'd1);
            chk($sformatf("bp_hold%0d_rdata", k), resp_rdata, 32'hDEADBEAA);
            chk($sformatf("bp_hold%0d_rd", k), 32'(resp_rd), 32'd21);
            chk($sformatf("bp_hold%0d_req_ready", k), 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        req_valid  = 1'b0;
        @(negedge clk);
        chk("bp_release_req_ready", 32'(req_ready), 32'd1);
        chk("bp_release_resp_valid", 32'(resp_valid), 32'd0);
        chk("bp_no_stray_store", mem[3], 32'h0);
        do_req(mk(0, 3'b000, 32'h8, 32'h0, 5'd24, 32'hFFFFFFAA, 0, 2, 0, 32'd0, 32'h0), "bp_next");

        // Reset during WR0 of a store to word 1.
        @(negedge clk);
        req_write  = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h4;
        req_wdata  = 32'h11111111;
        req_rd     = 5'd23;
        req_valid  = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_wr0_strobe", 32'(mem_write), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_mem_write", 32'(mem_write), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_memory_address", memory_address, 32'h0);
        chk("rst_write_data", write_data, 32'h0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk("rst_resp_rd", 32'(resp_rd), 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (resp_valid) seen = 1;
        end
        chk("rst_no_response", 32'(seen), 32'd0);
        chk("rst_word1_unchanged", mem[1], 32'hBB000000);
        do_req(mk(0, 3'b010, 32'h4, 32'h0, 5'd25, 32'hBB000000, 0, 2, 0, 32'd0, 32'h0), "rst_readback");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu_mem_initiator.md
Name: lsu_mem_initiator

Overview:
- Load/store initiator between the core's execute stage and the word-addressed data memory.
- Accepts byte-addressed load/store requests through a valid/ready handshake and drives the memory's word interface (mem_write, memory_address, write_data, funct3, read_data).
- Performs sub-word read-modify-write, sign/zero extension, misaligned-access splitting across two words, and range checking.
- Returns one response per request through a valid/ready handshake.

Parameters:
- DEPTH, 16: number of 32-bit words in the target memory. Legal word indices are 0..DEPTH-1.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  request accepted when high together with req_valid at a clk edge.
- req_write  input  1  1 = store, 0 = load.
- req_funct3  input  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data; low bytes are used per width.
- req_rd  input  5  destination register tag, returned on resp_rd.
- resp_valid  output  1  response present.
- resp_ready  input  1  response consumed when high together with resp_valid at a clk edge.
- resp_rdata  output  32  extended load data; 0 for stores and errors.
- resp_rd  output  5  tag of the completed request.
- resp_err  output  1  illegal funct3 or out-of-range access.
- mem_write  output  1  memory write strobe, combinational from state.
- mem_funct3  output  3  constant 3'b010; the initiator always issues full words.
- memory_address  output  32  word index, zero-extended.
- write_data  output  32  merged word to write.
- read_data  input  32  combinational memory read of memory_address.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; req_ready=1.
  - resp_valid, resp_err, mem_write = 0; resp_rdata, resp_rd, memory_address, write_data = 0.
  - Reset mid-operation abandons the request. mem_write drops in the same cycle reset asserts. No response is issued.
- States: IDLE, RD0, WR0, RD1, WR1, RESP.
- req_ready = (state==IDLE).
- On acceptance, latch addr, funct3, wdata, rd, write.
  - size = 1/2/4 bytes; off = addr[1:0]; w0 = addr[31:2]; cross = (off+size > 4); w1 = w0+1.
- Error cases go IDLE->RESP with resp_err=1 and no memory access:
  - funct3 is 011, 110 or 111.
  - A store with funct3 100 or 101.
  - w0 >= DEPTH.
  - cross=1 and w1 >= DEPTH.
- Load sequence:
  - IDLE->RD0: memory_address=w0; capture read_data at the edge.
  - Then ->RD1 if cross, else ->RESP.
  - RD1: memory_address=w1; capture read_data.
  - Byte lanes are little-endian. Bytes off..off+size-1 come from the 8-byte concatenation {word1,word0}.
  - B/H results are sign-extended; BU/HU results are zero-extended.
- Store sequence (read-modify-write):
  - RD0: capture word0.
  - WR0: mem_write=1, memory_address=w0, write_data = word0 with lanes off..min(off+size,4)-1 replaced by wdata bytes 0...
  - If cross: RD1, then WR1 writing the remaining wdata bytes into the low lanes of word1.
  - Then ->RESP.
- Latency from the acceptance edge to resp_valid rising:
  - Error: 1 cycle.
  - Aligned load: 2 cycles. Crossing load: 3 cycles.
  - Aligned store: 3 cycles. Crossing store: 5 cycles.
- RESP:
  - resp_valid=1; outputs are held stable until resp_valid && resp_ready, then ->IDLE.
  - A new request cannot be accepted in the same edge as the handshake (req_ready=0 in RESP).
- mem_write is asserted only in WR0/WR1, for exactly one cycle each.
- memory_address is held at the last value outside RD/WR states.
- Address wrap at 2^32: w1 overflow is treated as out of range (error).

Test Plan:
- SW addr 0x8, wdata 0xDEADBEEF -> WR0 cycle shows mem_write=1, memory_address=2, write_data=0xDEADBEEF; resp_err=0, resp_rdata=0, resp_valid 3 cycles after acceptance.
- After the above: LB 0xB -> resp_rdata 0xFFFFFFDE; LBU 0xB -> 0x000000DE; LHU 0xA -> 0x0000DEAD. Each response arrives 2 cycles after acceptance with resp_rd echoing the request tag.
- SH addr 0x7, wdata 0x1234AABB over zeroed word1:
  - word1 becomes 0xBB000000.
  - word2 becomes 0xDEADBEAA (two write strobes, 5-cycle latency).
  - Then LH 0x7 -> 0xFFFFAABB in 3 cycles.
- Error cases, each with a 1-cycle response, resp_err=1 and no mem_write at any point:
  - LW addr 0x40 (DEPTH=16).
  - LW addr 0x3E (crosses to word 16).
  - funct3 011.
  - SB with funct3 100.
- Hold resp_ready=0 for 4 cycles -> resp_valid and data remain stable, req_ready=0; release -> IDLE next edge, new request accepted.
- Assert rst during WR0 of SW 0x4 -> mem_write falls immediately, all outputs reset; word1 unchanged on readback; no response issued.
